// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging two single-beat masters onto one registered
// downstream request stage; read returns are steered back by mem_readdataid.
module mem_arbiter #(
  parameter int ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [31:0]       a_writedata,
  input  logic [3:0]        a_writedatamask,
  output logic              a_waitrequest,
  output logic [31:0]       a_readdata,
  output logic              a_readdatavalid,

  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [31:0]       b_writedata,
  input  logic [3:0]        b_writedatamask,
  output logic              b_waitrequest,
  output logic [31:0]       b_readdata,
  output logic              b_readdatavalid,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_writedatamask,
  output logic [1:0]        mem_id,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic [1:0]        mem_readdataid
);

  logic out_valid;
  logic last_b;
  logic a_req;
  logic b_req;
  logic grant_a;
  logic grant_b;
  logic load;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  // With both requesting, the port that was not served last wins.
  assign grant_a = a_req & (!b_req | last_b);
  assign grant_b = b_req & (!a_req | !last_b);

  assign load = !out_valid | !mem_waitrequest;

  // Reset is folded in so neither master sees an acceptance during reset.
  assign a_waitrequest = reset | !(load & grant_a);
  assign b_waitrequest = reset | !(load & grant_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_id            <= 2'b00;
      mem_address       <= '0;
      mem_writedata     <= 32'h0;
      mem_writedatamask <= 4'h0;
      last_b            <= 1'b1;
    end else if (load) begin
      if (grant_a) begin
        out_valid         <= 1'b1;
        mem_read          <= a_read;
        mem_write         <= a_write;
        mem_id            <= 2'b01;
        mem_address       <= a_address;
        mem_writedata     <= a_writedata;
        mem_writedatamask <= a_writedatamask;
        last_b            <= 1'b0;
      end else if (grant_b) begin
        out_valid         <= 1'b1;
        mem_read          <= b_read;
        mem_write         <= b_write;
        mem_id            <= 2'b10;
        mem_address       <= b_address;
        mem_writedata     <= b_writedata;
        mem_writedatamask <= b_writedatamask;
        last_b            <= 1'b1;
      end else begin
        // Payload is left as-is; only the qualifiers are dropped when idle.
        out_valid <= 1'b0;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        mem_id    <= 2'b00;
      end
    end
  end

  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;
  assign a_readdatavalid = (mem_readdataid == 2'b01);
  assign b_readdatavalid = (mem_readdataid == 2'b10);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, meaning word-address width of all address ports.
REQ-002 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports a_read, a_write  input  1 each  port A read/write request.
REQ-005 SHALL have ports a_address  input  ADDR_W; a_writedata  input  32; a_writedatamask  input  4  (port A request payload).
REQ-006 SHALL have ports a_waitrequest  output  1  (request not accepted this cycle); a_readdata  output  32; a_readdatavalid  output  1  (port A read return).
REQ-007 SHALL have ports b_* identical to REQ-004..006 for port B.
REQ-008 SHALL have ports mem_read, mem_write  output  1 each; mem_address  output  ADDR_W; mem_writedata  output  32; mem_writedatamask  output  4; mem_id  output  2  (downstream request toward the SSRAM controller).
REQ-009 SHALL have ports mem_waitrequest  input  1  (downstream stall); mem_readdata  input  32; mem_readdataid  input  2  (0 = no read data this cycle).

Function
REQ-010 SHALL merge two single-beat masters (A, B) onto one downstream mem_* bus through one registered output stage (out_valid).
REQ-011 SHALL define port request as p_read | p_write; simultaneous read and write on one port is forwarded unchanged, not checked.
REQ-012 SHALL compute load = !out_valid | !mem_waitrequest.
REQ-013 SHALL hold every mem_* output stable while out_valid & mem_waitrequest.
REQ-014 SHALL arbitrate round-robin: only one port requesting -> grant it; both requesting -> grant the port not granted last; no request -> no grant.
REQ-015 SHALL update the last-granted pointer only when a grant is accepted (load & grant).
REQ-016 SHALL drive p_waitrequest = !(load & grant==p) combinationally; a requesting port not granted sees waitrequest=1.
REQ-017 SHALL, on acceptance in cycle N, present the request on mem_* in cycle N+1 (1-cycle latency), with mem_id = 2'b01 for A, 2'b10 for B.
REQ-018 SHALL, on load with no grant, clear mem_read, mem_write, mem_id and out_valid; payload outputs may hold prior values.
REQ-019 SHALL, when out_valid & !mem_waitrequest & new grant in the same cycle, replace the output stage back-to-back (one request per cycle sustained).
REQ-020 SHALL broadcast mem_readdata to a_readdata and b_readdata unregistered.
REQ-021 SHALL assert a_readdatavalid iff mem_readdataid==2'b01, b_readdatavalid iff mem_readdataid==2'b10, same cycle; id 2'b11 and 2'b00 SHALL assert neither.
REQ-022 SHALL never reorder or drop an accepted request; read returns follow downstream order.

Reset
REQ-023 SHALL, while reset is high, force out_valid=0, mem_read=0, mem_write=0, mem_id=0, mem_address=0, mem_writedata=0, mem_writedatamask=0, last-granted=B.
REQ-024 SHALL drive a_waitrequest=b_waitrequest=1 while reset is high, regardless of requests.
REQ-025 SHALL, on reset mid-transfer, discard the output stage immediately (asynchronously); first grant after reset is A if both request.

Verification
REQ-026 Reset release, both ports request reads (A addr 0x10, B addr 0x20) -> cycle N: a_waitrequest=0, b_waitrequest=1; N+1: mem_read=1, mem_address=0x10, mem_id=01; next grant B, mem_address=0x20, mem_id=10.
REQ-027 Both ports request continuously, mem_waitrequest=0 -> mem_id alternates 01,10,01,10 every cycle, no idle cycles.
REQ-028 B writes 0xDEADBEEF mask 0xF to 0x5, mem_waitrequest held 1 for 3 cycles -> mem_* stable all 3 cycles, b_waitrequest=1 for any new B request; released next cycle after mem_waitrequest=0.
REQ-029 mem_readdataid sequence 01,00,10,11 with mem_readdata 0x1,0x2,0x3,0x4 -> a_readdatavalid=1 only cycle 1 (data 0x1), b_readdatavalid=1 only cycle 3 (data 0x3), none for id 11.
REQ-030 Assert reset while mem_write=1 and mem_waitrequest=1 -> mem_write=0, mem_id=0 same cycle, both waitrequests=1 until reset drops.
REQ-031 Only A requesting 4 consecutive cycles, mem_waitrequest=0 -> 4 accepted writes, mem_* reflects each one cycle later, b_waitrequest irrelevant, pointer ends at A.
